ipml_sync_prefetch_fifo_v2_0: RTL
=================================

# ipml_sync_prefetch_fifo_v2_0

Single-clock first-word-fall-through FIFO: a parametrised successor to the dual-clock prefetch FIFO used on the DDR read path. It keeps the same valid/enable handshake style on both sides (inferred 1-cycle-latency RAM plus a 2-entry output register stage) and adds a total-occupancy water level, programmable almost-full/almost-empty flags, a synchronous flush, and optional sticky error flags. It sits between single-clock-domain pixel/DDR-burst stages that need backpressure without a clock crossing.

## Interface
- DATA_WIDTH, 32, data width in bits (1..1152)
- DEPTH_WIDTH, 9, RAM address width; RAM depth 2^DEPTH_WIDTH (4..16)
- AF_LEVEL, 2^DEPTH_WIDTH-4, almost_full asserts when water_level >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when water_level <= AE_LEVEL
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous assert, active low
- flush  in  1  synchronous clear of all contents
- wr_data  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- wr_vld  out  1  write ready; a write is accepted when wr_en & wr_vld
- rd_data  out  DATA_WIDTH  head-of-FIFO data, valid while rd_vld
- rd_en  in  1  read acknowledge; pop = rd_en & rd_vld
- rd_vld  out  1  head data valid
- water_level  out  DEPTH_WIDTH+1  total entries held (RAM + in-flight + output stage)
- almost_full  out  1  registered threshold flag
- almost_empty  out  1  registered threshold flag
- overflow  out  1  sticky: write attempted while not ready
- underflow  out  1  sticky: read attempted while not valid

## Operation
- Storage: RAM of 2^DEPTH_WIDTH words with wrapping write/read pointers of DEPTH_WIDTH bits; ram_cnt tracks unread RAM words (0..2^DEPTH_WIDTH).
- Output stage: 2-entry register FIFO; out_cnt 0..2; rd_data = head entry; rd_vld = (out_cnt != 0).
- Prefetch: a RAM read is issued in a cycle when ram_cnt > 0 and (out_cnt + inflight - pop) < 2; inflight is set for one cycle, and the returned word is pushed into the output stage on the following edge.
- wr_vld = (ram_cnt < 2^DEPTH_WIDTH), a function of registered state only. A RAM read in the same cycle does not make a full FIFO ready.
- Total capacity = 2^DEPTH_WIDTH + 2.
- water_level = ram_cnt + inflight + out_cnt, registered. It updates on the same edge as the causing accept/pop: +1 per write accept, -1 per pop, net 0 when both occur together.
- almost_full and almost_empty are registered and consistent with the water_level of the same cycle.
- Flush: every counter, pointer, inflight and output entry is cleared on that edge. A write or pop presented in the flush cycle is ignored. Outputs take their reset values on the next cycle, except that sticky flags clear.
- Reset values: wr_vld 1, rd_vld 0, rd_data 0, water_level 0, almost_full 0, almost_empty 1, overflow 0, underflow 0.

## Timing
- First-word latency: write accepted in cycle N; read issued in N+1; RAM data in N+2; rd_vld high in N+3 with that word on rd_data.
- Sustained throughput: 1 word/cycle both sides. The steady state is out_cnt=1 and inflight=1 with a pop every cycle.
- rd_data is held stable while rd_vld & ~rd_en. The next entry appears the cycle after a pop.
- Reset assertion clears state immediately. Mid-burst reset discards all data. The first write after rst_n deasserts follows the N+3 rule.

## Configuration
- IPML_PREFETCH_FIFO_ERR_EN defined: overflow sets on any cycle with wr_en & ~wr_vld, and underflow sets on rd_en & ~rd_vld. Both hold until flush or reset. Rejected writes never corrupt data.
- Not defined: overflow and underflow are tied 0 and no error logic is synthesised. All other behaviour is identical.

## Test plan
- Test parameters: DEPTH_WIDTH=4, AF_LEVEL=14, AE_LEVEL=4. Single write 0xA5 at cycle 0 with rd_en=0 -> rd_vld=1 and rd_data=0xA5 at cycle 3; water_level=1; almost_empty=1.
- Continuous writes 1..20 with rd_en=0 -> exactly 18 accepted; wr_vld=0 after the 18th; water_level=18; almost_full=1; with ERR_EN, overflow=1 after the 19th attempt.
- After filling, rd_en=1 held continuously -> values 1..18 are popped in order, one per cycle with no bubbles. wr_vld rises the cycle after ram_cnt drops below 16. rd_vld falls after 18 pops.
- Simultaneous write/pop every cycle at water_level=8 -> water_level stays 8 and the data order is preserved across pointer wrap (run 40 cycles).
- Flush asserted with water_level=10 and wr_en=1 in the same cycle -> next cycle water_level=0, rd_vld=0, almost_empty=1, sticky flags cleared, and the flushed-cycle write is not stored.
- rd_en=1 on an empty FIFO -> with ERR_EN, underflow=1 and stays set; water_level remains 0; without ERR_EN, underflow stays 0.

Source files
------------

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Single-clock FWFT FIFO: 1-cycle-latency RAM feeding a 2-entry output register stage,
// with water level, almost flags and sync flush. Define IPML_PREFETCH_FIFO_ERR_EN for sticky error flags.
module ipml_sync_prefetch_fifo_v2_0 #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WIDTH = 9,
  parameter int unsigned AF_LEVEL    = (1 << DEPTH_WIDTH) - 4,
  parameter int unsigned AE_LEVEL    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  rd_vld,
  output logic [DEPTH_WIDTH:0]  water_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned    DEPTH  = 1 << DEPTH_WIDTH;
  localparam int unsigned    LW     = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0]  AF_LVL = LW'(AF_LEVEL);
  localparam logic [LW-1:0]  AE_LVL = LW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  ram_rdata_q;

  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          ram_cnt_q, ram_cnt_d;
  logic [LW-1:0]          water_q, water_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0]  out0_q, out0_d;
  logic [DATA_WIDTH-1:0]  out1_q, out1_d;
  logic                   af_q, af_d;
  logic                   ae_q, ae_d;

  logic wr_acc;
  logic pop;
  logic rd_issue;

  // ram_cnt reaches DEPTH exactly when full, so its MSB alone is the full flag.
  assign wr_vld       = ~ram_cnt_q[DEPTH_WIDTH];
  assign rd_vld       = (out_cnt_q != 2'd0);
  assign rd_data      = out0_q;
  assign water_level  = water_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

  assign wr_acc   = wr_en & wr_vld & ~flush;
  assign pop      = rd_en & rd_vld & ~flush;
  // Fetch only if the word cannot overrun the output stage once it lands next edge.
  assign rd_issue = ~flush & (ram_cnt_q != '0) &
                    (({1'b0, out_cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q + DEPTH_WIDTH'(wr_acc);
    rd_ptr_d   = rd_ptr_q + DEPTH_WIDTH'(rd_issue);
    ram_cnt_d  = ram_cnt_q + LW'(wr_acc) - LW'(rd_issue);
    inflight_d = rd_issue;
    water_d    = water_q + LW'(wr_acc) - LW'(pop);
    out_cnt_d  = out_cnt_q;
    out0_d     = out0_q;
    out1_d     = out1_q;

    case ({inflight_q, pop})
      2'b01: begin
        out0_d    = out1_q;
        out_cnt_d = out_cnt_q - 2'd1;
      end
      2'b10: begin
        if (out_cnt_q == 2'd0) out0_d = ram_rdata_q;
        else                   out1_d = ram_rdata_q;
        out_cnt_d = out_cnt_q + 2'd1;
      end
      2'b11: begin
        if (out_cnt_q == 2'd1) begin
          out0_d = ram_rdata_q;
        end else begin
          out0_d = out1_q;
          out1_d = ram_rdata_q;
        end
      end
      default: ;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      water_d    = '0;
      out_cnt_d  = 2'd0;
      out0_d     = '0;
      out1_d     = '0;
    end

    af_d = (water_d >= AF_LVL);
    ae_d = (water_d <= AE_LVL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      water_q    <= '0;
      out_cnt_q  <= 2'd0;
      out0_q     <= '0;
      out1_q     <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      water_q    <= water_d;
      out_cnt_q  <= out_cnt_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM;
  // counters guarantee no stale word is ever presented.
  always_ff @(posedge clk) begin
    if (wr_acc)   mem[wr_ptr_q] <= wr_data;
    if (rd_issue) ram_rdata_q   <= mem[rd_ptr_q];
  end

`ifdef IPML_PREFETCH_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & ~wr_vld);
    unf_d = unf_q | (rd_en & ~rd_vld);
    if (flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
